// File: rtl/seg_decoder_if.sv
// Bundles the decoder's data, control and result signals so that both ends
// connect through a single interface port.
interface seg_decoder_if;
    logic       en;
    logic [6:0] seg_in;
    logic       clr_err;
    logic [3:0] hex_out;
    logic       hex_valid;
    logic       err;
    logic [7:0] err_cnt;

    modport master (
        output en, seg_in, clr_err,
        input  hex_out, hex_valid, err, err_cnt
    );

    modport slave (
        input  en, seg_in, clr_err,
        output hex_out, hex_valid, err, err_cnt
    );
endinterface

// File: rtl/seg_decoder.sv
// Debounced seven-segment decoder: a pattern must stay identical for
// STABLE_CYCLES consecutive samples before it is decoded to a hex nibble.
// Illegal stable patterns pulse err and are counted in a saturating counter.
module seg_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic         clk,
    input logic         rst,
    seg_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    state_t     state_q, state_d;
    logic [6:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       dec;

    logic [3:0] hex_out_q, hex_out_d;
    logic       hex_valid_q, hex_valid_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [4:0] lookup;

    // Returns {legal, nibble} for an active-low a..g pattern.
    function automatic logic [4:0] seg_lookup(input logic [6:0] p);
        case (p)
            7'h40: seg_lookup = 5'h10;
            7'h79: seg_lookup = 5'h11;
            7'h24: seg_lookup = 5'h12;
            7'h30: seg_lookup = 5'h13;
            7'h19: seg_lookup = 5'h14;
            7'h12: seg_lookup = 5'h15;
            7'h02: seg_lookup = 5'h16;
            7'h78: seg_lookup = 5'h17;
            7'h00: seg_lookup = 5'h18;
            7'h18: seg_lookup = 5'h19;
            7'h08: seg_lookup = 5'h1A;
            7'h03: seg_lookup = 5'h1B;
            7'h46: seg_lookup = 5'h1C;
            7'h21: seg_lookup = 5'h1D;
            7'h06: seg_lookup = 5'h1E;
            7'h0E: seg_lookup = 5'h1F;
            default: seg_lookup = 5'h00;
        endcase
    endfunction

    // Saturating increment keeps the stability count from wrapping.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : 8'(cnt_q + 8'd1);

    // State register: FSM state, candidate pattern and stability count.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= 7'h7F;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: track the current candidate and decide when it is stable.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        dec     = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    cand_d  = bus.seg_in;
                    cnt_d   = 8'd1;
                    state_d = SETTLE;
                end
                SETTLE: begin
                    if (bus.seg_in != cand_q) begin
                        cand_d = bus.seg_in;
                        cnt_d  = 8'd1;
                    end else begin
                        cnt_d  = cnt_inc;
                    end
                end
                HOLD: begin
                    if (bus.seg_in != cand_q) begin
                        cand_d  = bus.seg_in;
                        cnt_d   = 8'd1;
                        state_d = SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A window that reaches the threshold on this edge decodes now;
            // with a threshold of 1 that is the same edge that loads cand.
            if (state_d == SETTLE && cnt_d >= STABLE) begin
                dec     = 1'b1;
                state_d = HOLD;
            end
        end
    end

    // Output logic: turn a due decode into a valid/err pulse and update results.
    always_comb begin
        lookup      = seg_lookup(cand_d);
        hex_valid_d = dec & lookup[4];
        err_d       = dec & ~lookup[4];
        hex_out_d   = hex_valid_d ? lookup[3:0] : hex_out_q;
        if (bus.clr_err)
            err_cnt_d = 8'd0;
        else if (err_d && err_cnt_q != 8'hFF)
            err_cnt_d = 8'(err_cnt_q + 8'd1);
        else
            err_cnt_d = err_cnt_q;
    end

    // Output registers: pulses last exactly one cycle after the decoding edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out_q   <= 4'd0;
            hex_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            hex_out_q   <= hex_out_d;
            hex_valid_q <= hex_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.hex_out   = hex_out_q;
    assign bus.hex_valid = hex_valid_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_seg_decoder.sv
// Self-checking bench: two decoders (thresholds 4 and 1) share one stimulus
// stream and are compared every cycle against a run-length reference model.
module tb_seg_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic       clr_err = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    seg_decoder_if if4 ();
    seg_decoder_if if1 ();

    assign if4.en = en;
    assign if4.seg_in = seg_in;
    assign if4.clr_err = clr_err;
    assign if1.en = en;
    assign if1.seg_in = seg_in;
    assign if1.clr_err = clr_err;

    seg_decoder #(.STABLE_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    seg_decoder #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    // Legal glyph table: index is the nibble.
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model, one slot per decoder: run length of identical enabled samples.
    int         thr [2] = '{4, 1};
    logic [6:0] last [2];
    int         run [2];
    bit         done [2];
    int         m_hex [2];
    int         m_valid [2];
    int         m_err [2];
    int         m_cnt [2];

    function automatic int nibble_of(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (SEG_TBL[i] == p) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            run[m] = 0; done[m] = 0; last[m] = 7'h7F;
            m_hex[m] = 0; m_valid[m] = 0; m_err[m] = 0; m_cnt[m] = 0;
        end
    endtask

    task automatic model_edge();
        int n;
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0;
            m_err[m] = 0;
            if (!en) begin
                run[m] = 0;
                done[m] = 0;
            end else begin
                if (run[m] > 0 && seg_in == last[m]) begin
                    run[m]++;
                end else begin
                    last[m] = seg_in;
                    run[m] = 1;
                    done[m] = 0;
                end
                if (!done[m] && run[m] >= thr[m]) begin
                    done[m] = 1;
                    n = nibble_of(last[m]);
                    if (n >= 0) begin
                        m_hex[m] = n;
                        m_valid[m] = 1;
                    end else begin
                        m_err[m] = 1;
                        if (m_cnt[m] < 255) m_cnt[m]++;
                    end
                end
            end
            if (clr_err) m_cnt[m] = 0;
        end
    endtask

    task automatic compare_all();
        check("s4_valid", int'(if4.hex_valid), m_valid[0]);
        check("s4_err",   int'(if4.err),       m_err[0]);
        check("s4_hex",   int'(if4.hex_out),   m_hex[0]);
        check("s4_cnt",   int'(if4.err_cnt),   m_cnt[0]);
        check("s1_valid", int'(if1.hex_valid), m_valid[1]);
        check("s1_err",   int'(if1.err),       m_err[1]);
        check("s1_hex",   int'(if1.hex_out),   m_hex[1]);
        check("s1_cnt",   int'(if1.err_cnt),   m_cnt[1]);
        check("s4_excl",  int'(if4.hex_valid & if4.err), 0);
        check("s1_excl",  int'(if1.hex_valid & if1.err), 0);
    endtask

    // One clock: inputs applied at the falling edge, results sampled at the next one.
    task automatic step(input logic e, input logic [6:0] s, input logic c);
        en = e;
        seg_in = s;
        clr_err = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] p;
        p = 7'($urandom);
        while (nibble_of(p) >= 0) p = 7'($urandom);
        return p;
    endfunction

    initial begin
        logic [6:0] pat;
        int pulses;

        // Reset state
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Legal pattern held 4 edges decodes once, then stays quiet
        hold(7'h24, 4);
        check("first_hex", int'(if4.hex_out), 2);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 7'h24, 1'b0);
            pulses += int'(if4.hex_valid);
        end
        check("no_repulse", pulses, 0);

        // Short glitch then a new stable pattern
        hold(7'h24, 2);
        hold(7'h30, 4);
        check("glitch_hex", int'(if4.hex_out), 3);

        // Illegal stable pattern
        hold(7'h7F, 4);
        check("illegal_cnt", int'(if4.err_cnt), 1);
        check("illegal_hex", int'(if4.hex_out), 3);

        // Clear on the same edge as an illegal decode
        hold(7'h79, 4);
        hold(7'h55, 3);
        step(1'b1, 7'h55, 1'b1);
        check("clr_err_pulse", int'(if4.err), 1);
        check("clr_err_cnt", int'(if4.err_cnt), 0);

        // en dropped on edge 3 of a window, then restored with the same pattern
        hold(7'h19, 2);
        step(1'b0, 7'h19, 1'b0);
        hold(7'h19, 3);
        check("en_restore_early", int'(if4.hex_valid), 0);
        hold(7'h19, 1);
        check("en_restore_valid", int'(if4.hex_valid), 1);

        // Asynchronous reset mid-window clears everything at once
        hold(7'h12, 2);
        en = 1'b1;
        seg_in = 7'h12;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_hex_now", int'(if4.hex_out), 0);
        @(negedge clk);
        rst = 1'b0;
        hold(7'h12, 3);
        check("rst_no_early", int'(if4.hex_valid), 0);
        hold(7'h12, 1);
        check("rst_full_window", int'(if4.hex_valid), 1);

        // Randomized traffic
        pat = 7'h40;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) >= 45)
                pat = ($urandom_range(99) < 70) ? SEG_TBL[$urandom_range(15)] : 7'($urandom);
            step(($urandom_range(99) < 92) ? 1'b1 : 1'b0, pat, ($urandom_range(99) < 4) ? 1'b1 : 1'b0);
        end

        // Error-counter saturation via illegal/legal alternations
        step(1'b1, 7'h40, 1'b1);
        for (int i = 0; i < 300; i++) begin
            hold(rand_illegal(), 4);
            hold(SEG_TBL[$urandom_range(15)], 4);
        end
        check("sat_cnt4", int'(if4.err_cnt), 255);
        check("sat_cnt1", int'(if1.err_cnt), 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, legal range 1..255: consecutive identical samples required before a pattern is accepted.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port en, input, 1, decode enable; 0 forces IDLE.
REQ-005 The block SHALL have port seg_in, input, 7, active-low segment pattern, bit0=a .. bit6=g.
REQ-006 The block SHALL have port clr_err, input, 1, synchronous clear of err_cnt.
REQ-007 The block SHALL have port hex_out, output, 4, last successfully decoded nibble.
REQ-008 The block SHALL have port hex_valid, output, 1, one-cycle pulse when hex_out is updated.
REQ-009 The block SHALL have port err, output, 1, one-cycle pulse when a stable pattern is illegal.
REQ-010 The block SHALL have port err_cnt, output, 8, count of illegal stable patterns, saturating at 255.

Function
REQ-011 Legal patterns (hex seg_in -> nibble) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F; all other 112 codes are illegal.
REQ-012 FSM states SHALL be IDLE, SETTLE and HOLD, with internal 7-bit register cand and 8-bit counter cnt.
REQ-013 In IDLE with en=1, the block SHALL load cand=seg_in, set cnt=1, and go to SETTLE.
REQ-014 In SETTLE, a seg_in differing from cand SHALL reload cand=seg_in and set cnt=1, staying in SETTLE.
REQ-015 In SETTLE, a seg_in equal to cand SHALL increment cnt.
REQ-016 When cnt reaches STABLE_CYCLES, the block SHALL decode cand and go to HOLD; with STABLE_CYCLES=1, the decode occurs on the edge that loads cand.
REQ-017 Latency SHALL be: a pattern first sampled at edge k and held through edge k+STABLE_CYCLES-1 yields hex_valid or err high in the cycle after edge k+STABLE_CYCLES-1.
REQ-018 A legal decode SHALL update hex_out and pulse hex_valid for exactly one cycle; err stays 0.
REQ-019 An illegal decode SHALL pulse err for exactly one cycle, increment err_cnt unless it is already 255, and leave hex_out unchanged.
REQ-020 In HOLD, the block SHALL produce no further pulses while seg_in equals cand; a differing seg_in SHALL load cand=seg_in, set cnt=1, and go to SETTLE.
REQ-021 en=0 in any state SHALL force IDLE on the next edge, suppress any decode due on that edge, and leave hex_out and err_cnt held.
REQ-022 clr_err=1 SHALL set err_cnt=0 on that edge, taking priority over a simultaneous increment; the err pulse is still emitted.
REQ-023 hex_valid and err SHALL never be high in the same cycle.
REQ-024 The cnt increment SHALL saturate so that it never wraps.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, cand=7'h7F, cnt=0, hex_out=0, hex_valid=0, err=0, err_cnt=0, regardless of clk.
REQ-026 Reset asserted mid-SETTLE SHALL discard the partial count, so no pulse follows reset release until a full new stability window completes.

Verification (STABLE_CYCLES=4 unless noted)
REQ-027 Scenario: en=1, seg_in=7'h24 held 4 edges -> hex_valid one cycle, hex_out=2; held 20 more edges -> no further pulse.
REQ-028 Scenario: seg_in 7'h24 for 2 edges, then 7'h30 held 4 edges -> exactly one hex_valid, hex_out=3, no pulse for 2.
REQ-029 Scenario: seg_in=7'h7F stable -> err one cycle, err_cnt=1, hex_out unchanged; repeat 300 distinct illegal/legal alternations -> err_cnt saturates at 255.
REQ-030 Scenario: clr_err=1 on the same edge as an illegal decode -> err pulses and err_cnt=0 afterwards.
REQ-031 Scenario: en dropped on edge 3 of a window -> no pulse; en restored with the same pattern -> a full 4-edge window is required, then hex_valid.
REQ-032 Scenario: rst pulsed asynchronously mid-SETTLE -> all outputs 0 immediately; with STABLE_CYCLES=1, each edge's new legal pattern yields hex_valid in the next cycle.
